// File: rtl/idu_regfile16.sv
// rtl/idu_regfile16.sv - 16-bit register pairs, operand latch and incrementer/decrementer
// Optional protocol checker is built only when IDU_PROTOCOL_CHECK_EN is defined.
module idu_regfile16 #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [15:0] SP_RESET = 16'hFFFE
) (
   input  logic        i_Clk,
   input  logic        i_Reset_n,
   input  logic [5:0]  i_Read16,
   input  logic [5:0]  i_Write16,
   input  logic [1:0]  i_Increment16,
   input  logic [5:0]  i_Load8_Sel,
   input  logic        i_Load8_Hi,
   input  logic [7:0]  i_Data8,
   output logic [15:0] o_Addr,
   output logic [15:0] o_IDU_Result,
   output logic [15:0] o_PC,
   output logic [15:0] o_BC,
   output logic [15:0] o_DE,
   output logic [15:0] o_HL,
   output logic [15:0] o_SP,
   output logic [15:0] o_WZ,
   output logic        o_Protocol_Err
);

   // Pair index map shared by every select bus: PC, BC, DE, HL, SP, WZ
   localparam int PC_IDX = 0;
   localparam int BC_IDX = 1;
   localparam int DE_IDX = 2;
   localparam int HL_IDX = 3;
   localparam int SP_IDX = 4;
   localparam int WZ_IDX = 5;

   logic [15:0] pair_q [6];
   logic [15:0] latch_q;
   logic [15:0] read_val;
   logic [15:0] idu_val;

   // Read mux: scan from the top down so the lowest-index selected pair wins
   always_comb begin
      read_val = 16'h0000;
      for (int i = 5; i >= 0; i--) begin
         if (i_Read16[i]) begin
            read_val = pair_q[i];
         end
      end
   end

   // Incrementer/decrementer acting on the pre-edge latch, modulo 2^16
   always_comb begin
      case (i_Increment16)
         2'b01:   idu_val = latch_q + 16'h0001;
         2'b11:   idu_val = latch_q - 16'h0001;
         default: idu_val = latch_q;
      endcase
   end

   // Operand latch: captures the selected pair's pre-edge value, holds when idle
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         latch_q <= 16'h0000;
      end else if (|i_Read16) begin
         latch_q <= read_val;
      end
   end

   // Pair storage: IDU write-back takes the whole pair over any byte load to it
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         pair_q[PC_IDX] <= PC_RESET;
         pair_q[BC_IDX] <= 16'h0000;
         pair_q[DE_IDX] <= 16'h0000;
         pair_q[HL_IDX] <= 16'h0000;
         pair_q[SP_IDX] <= SP_RESET;
         pair_q[WZ_IDX] <= 16'h0000;
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (i_Write16[i]) begin
               pair_q[i] <= idu_val;
            end else if (i_Load8_Sel[i]) begin
               if (i_Load8_Hi) begin
                  pair_q[i][15:8] <= i_Data8;
               end else begin
                  pair_q[i][7:0] <= i_Data8;
               end
            end
         end
      end
   end

`ifdef IDU_PROTOCOL_CHECK_EN
   logic read_seen_q;
   logic err_q;
   logic multi_read;
   logic orphan_write;
   logic bad_dir;

   // A write is legitimate only if a read has happened since the last write,
   // counting a read on the same edge as the write
   assign multi_read   = (i_Read16 & (i_Read16 - 6'd1)) != 6'd0;
   assign orphan_write = (|i_Write16) && !(|i_Read16) && !read_seen_q;
   assign bad_dir      = (i_Increment16 == 2'b10);

   // Sticky error flag plus the read-since-write tracker
   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         read_seen_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (multi_read || orphan_write || bad_dir) begin
            err_q <= 1'b1;
         end
         if (|i_Read16) begin
            read_seen_q <= 1'b1;
         end else if (|i_Write16) begin
            read_seen_q <= 1'b0;
         end
      end
   end

   assign o_Protocol_Err = err_q;
`else
   assign o_Protocol_Err = 1'b0;
`endif

   assign o_Addr       = latch_q;
   assign o_IDU_Result = idu_val;
   assign o_PC         = pair_q[PC_IDX];
   assign o_BC         = pair_q[BC_IDX];
   assign o_DE         = pair_q[DE_IDX];
   assign o_HL         = pair_q[HL_IDX];
   assign o_SP         = pair_q[SP_IDX];
   assign o_WZ         = pair_q[WZ_IDX];

endmodule

// File: tb/tb_idu_regfile16.sv
// tb/tb_idu_regfile16.sv - vector table, corner sequences and random model check for idu_regfile16
module tb_idu_regfile16;

   logic        i_Clk = 1'b0;
   logic        i_Reset_n = 1'b0;
   logic [5:0]  i_Read16 = '0;
   logic [5:0]  i_Write16 = '0;
   logic [1:0]  i_Increment16 = '0;
   logic [5:0]  i_Load8_Sel = '0;
   logic        i_Load8_Hi = 1'b0;
   logic [7:0]  i_Data8 = '0;
   logic [15:0] o_Addr, o_IDU_Result, o_PC, o_BC, o_DE, o_HL, o_SP, o_WZ;
   logic        o_Protocol_Err;

`ifdef IDU_PROTOCOL_CHECK_EN
   localparam logic CHK_ON = 1'b1;
`else
   localparam logic CHK_ON = 1'b0;
`endif

   int n_vec = 0;
   int n_err = 0;

   idu_regfile16 dut (
      .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Read16(i_Read16), .i_Write16(i_Write16),
      .i_Increment16(i_Increment16), .i_Load8_Sel(i_Load8_Sel), .i_Load8_Hi(i_Load8_Hi),
      .i_Data8(i_Data8), .o_Addr(o_Addr), .o_IDU_Result(o_IDU_Result), .o_PC(o_PC),
      .o_BC(o_BC), .o_DE(o_DE), .o_HL(o_HL), .o_SP(o_SP), .o_WZ(o_WZ),
      .o_Protocol_Err(o_Protocol_Err)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      logic [5:0]  rd;
      logic [5:0]  wr;
      logic [1:0]  inc;
      logic [5:0]  ld;
      logic        hi;
      logic [7:0]  d;
      int          pair;
      logic [15:0] exp_pair;
      logic [15:0] exp_addr;
   } vec_t;

   vec_t vt [24];

   // Behavioural model state: pair values and the operand latch
   logic [15:0] m_reg [6];
   logic [15:0] m_latch;

   function automatic vec_t mkv(logic [5:0] rd, logic [5:0] wr, logic [1:0] inc, logic [5:0] ld,
                                logic hi, logic [7:0] d, int pair, logic [15:0] ep, logic [15:0] ea);
      vec_t v;
      v.rd = rd; v.wr = wr; v.inc = inc; v.ld = ld; v.hi = hi; v.d = d;
      v.pair = pair; v.exp_pair = ep; v.exp_addr = ea;
      return v;
   endfunction

   function automatic logic [15:0] dut_pair(int idx);
      case (idx)
         0: return o_PC;
         1: return o_BC;
         2: return o_DE;
         3: return o_HL;
         4: return o_SP;
         default: return o_WZ;
      endcase
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(logic [5:0] rd, logic [5:0] wr, logic [1:0] inc, logic [5:0] ld,
                        logic hi, logic [7:0] d);
      i_Read16 = rd; i_Write16 = wr; i_Increment16 = inc;
      i_Load8_Sel = ld; i_Load8_Hi = hi; i_Data8 = d;
   endtask

   task automatic idle();
      drive(6'b0, 6'b0, 2'b00, 6'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      i_Reset_n = 1'b0;
      idle();
      repeat (2) @(posedge i_Clk);
      #1 i_Reset_n = 1'b1;
   endtask

   task automatic check_reset_state(string tag);
      chk({tag, "_pc"}, o_PC, 16'h0000);
      chk({tag, "_bc"}, o_BC, 16'h0000);
      chk({tag, "_de"}, o_DE, 16'h0000);
      chk({tag, "_hl"}, o_HL, 16'h0000);
      chk({tag, "_sp"}, o_SP, 16'hFFFE);
      chk({tag, "_wz"}, o_WZ, 16'h0000);
      chk({tag, "_addr"}, o_Addr, 16'h0000);
      chk({tag, "_err"}, {15'b0, o_Protocol_Err}, 16'h0000);
   endtask

   // Model step: applies the register-transfer rules to one clock edge
   task automatic model_edge(logic [5:0] rd, logic [5:0] wr, logic [1:0] inc, logic [5:0] ld,
                             logic hi, logic [7:0] d);
      logic [15:0] res;
      logic [15:0] old [6];
      int first;
      res = m_latch;
      if (inc == 2'b01) res = 16'((32'(m_latch) + 1) % 65536);
      if (inc == 2'b11) res = 16'((32'(m_latch) + 65535) % 65536);
      for (int i = 0; i < 6; i++) old[i] = m_reg[i];
      first = -1;
      for (int i = 0; i < 6; i++) if (rd[i] && first < 0) first = i;
      if (first >= 0) m_latch = old[first];
      for (int i = 0; i < 6; i++) begin
         if (wr[i]) m_reg[i] = res;
         else if (ld[i]) m_reg[i] = hi ? {d, old[i][7:0]} : {old[i][15:8], d};
      end
   endtask

   function automatic logic [15:0] model_idu(logic [1:0] inc);
      if (inc == 2'b01) return 16'((32'(m_latch) + 1) % 65536);
      if (inc == 2'b11) return 16'((32'(m_latch) + 65535) % 65536);
      return m_latch;
   endfunction

   initial begin
      // Directed vector table starting from reset state
      vt[0]  = mkv(6'b000000, 6'b000000, 2'b00, 6'b001000, 1'b1, 8'h12, 3, 16'h1200, 16'h0000);
      vt[1]  = mkv(6'b000000, 6'b000000, 2'b00, 6'b001000, 1'b0, 8'hFF, 3, 16'h12FF, 16'h0000);
      vt[2]  = mkv(6'b001000, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00, 3, 16'h12FF, 16'h12FF);
      vt[3]  = mkv(6'b000000, 6'b001000, 2'b01, 6'b000000, 1'b0, 8'h00, 3, 16'h1300, 16'h12FF);
      vt[4]  = mkv(6'b000000, 6'b000000, 2'b00, 6'b010000, 1'b1, 8'h00, 4, 16'h00FE, 16'h12FF);
      vt[5]  = mkv(6'b000000, 6'b000000, 2'b00, 6'b010000, 1'b0, 8'h00, 4, 16'h0000, 16'h12FF);
      vt[6]  = mkv(6'b010000, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00, 4, 16'h0000, 16'h0000);
      vt[7]  = mkv(6'b000000, 6'b010000, 2'b11, 6'b000000, 1'b0, 8'h00, 4, 16'hFFFF, 16'h0000);
      vt[8]  = mkv(6'b010000, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00, 4, 16'hFFFF, 16'hFFFF);
      vt[9]  = mkv(6'b000000, 6'b010000, 2'b01, 6'b000000, 1'b0, 8'h00, 4, 16'h0000, 16'hFFFF);
      vt[10] = mkv(6'b000000, 6'b000000, 2'b00, 6'b000001, 1'b1, 8'h01, 0, 16'h0100, 16'hFFFF);
      vt[11] = mkv(6'b000000, 6'b000000, 2'b00, 6'b000001, 1'b0, 8'h00, 0, 16'h0100, 16'hFFFF);
      vt[12] = mkv(6'b000001, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00, 0, 16'h0100, 16'h0100);
      // Read and write of PC on one edge: latch takes pre-write PC, write uses pre-edge latch
      vt[13] = mkv(6'b000001, 6'b000001, 2'b01, 6'b000000, 1'b0, 8'h00, 0, 16'h0101, 16'h0100);
      vt[14] = mkv(6'b000001, 6'b000001, 2'b01, 6'b000000, 1'b0, 8'h00, 0, 16'h0101, 16'h0101);
      vt[15] = mkv(6'b000001, 6'b000001, 2'b01, 6'b000000, 1'b0, 8'h00, 0, 16'h0102, 16'h0101);
      vt[16] = mkv(6'b000000, 6'b000000, 2'b00, 6'b100000, 1'b1, 8'h34, 5, 16'h3400, 16'h0101);
      vt[17] = mkv(6'b000000, 6'b000000, 2'b00, 6'b100000, 1'b0, 8'h55, 5, 16'h3455, 16'h0101);
      vt[18] = mkv(6'b100000, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00, 5, 16'h3455, 16'h3455);
      vt[19] = mkv(6'b000000, 6'b000100, 2'b01, 6'b000100, 1'b0, 8'hAA, 2, 16'h3456, 16'h3455);
      vt[20] = mkv(6'b000000, 6'b000100, 2'b01, 6'b000010, 1'b1, 8'h77, 1, 16'h7700, 16'h3455);
      vt[21] = mkv(6'b000110, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00, 1, 16'h7700, 16'h7700);
      vt[22] = mkv(6'b000000, 6'b000000, 2'b01, 6'b000000, 1'b0, 8'h00, 1, 16'h7700, 16'h7700);
      vt[23] = mkv(6'b000010, 6'b000000, 2'b00, 6'b000010, 1'b0, 8'h33, 1, 16'h7733, 16'h7700);

      do_reset();
      check_reset_state("reset");

      for (int k = 0; k < 24; k++) begin
         drive(vt[k].rd, vt[k].wr, vt[k].inc, vt[k].ld, vt[k].hi, vt[k].d);
         @(posedge i_Clk);
         #1 idle();
         chk($sformatf("vec%0d_pair", k), dut_pair(vt[k].pair), vt[k].exp_pair);
         chk($sformatf("vec%0d_addr", k), o_Addr, vt[k].exp_addr);
      end
      chk("vec_de_after", o_DE, 16'h3456);

      // Asynchronous reset asserted mid-cycle with a write pending
      drive(6'b000000, 6'b111111, 2'b01, 6'b000000, 1'b0, 8'h00);
      #2 i_Reset_n = 1'b0;
      #1 check_reset_state("async_rst");
      @(posedge i_Clk);
      #1 chk("rst_hold_pc", o_PC, 16'h0000);
      idle();
      #1 i_Reset_n = 1'b1;

      // Protocol checks: multi-bit read, orphan write, direction without enable
      drive(6'b000110, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00);
      @(posedge i_Clk);
      #1 idle();
      chk("perr_multi_read", {15'b0, o_Protocol_Err}, {15'b0, CHK_ON});
      repeat (3) @(posedge i_Clk);
      #1 chk("perr_sticky", {15'b0, o_Protocol_Err}, {15'b0, CHK_ON});
      do_reset();
      drive(6'b000000, 6'b000001, 2'b01, 6'b000000, 1'b0, 8'h00);
      @(posedge i_Clk);
      #1 idle();
      chk("perr_orphan_write", {15'b0, o_Protocol_Err}, {15'b0, CHK_ON});
      do_reset();
      drive(6'b000000, 6'b000000, 2'b10, 6'b000000, 1'b0, 8'h00);
      @(posedge i_Clk);
      #1 idle();
      chk("perr_bad_dir", {15'b0, o_Protocol_Err}, {15'b0, CHK_ON});
      do_reset();
      drive(6'b001000, 6'b000000, 2'b00, 6'b000000, 1'b0, 8'h00);
      @(posedge i_Clk);
      #1 drive(6'b000000, 6'b001000, 2'b01, 6'b000000, 1'b0, 8'h00);
      @(posedge i_Clk);
      #1 idle();
      chk("perr_legal_rw", {15'b0, o_Protocol_Err}, 16'h0000);

      // Randomized run against the behavioural model
      do_reset();
      m_reg[0] = 16'h0000; m_reg[1] = 16'h0000; m_reg[2] = 16'h0000;
      m_reg[3] = 16'h0000; m_reg[4] = 16'hFFFE; m_reg[5] = 16'h0000;
      m_latch = 16'h0000;
      for (int c = 0; c < 400; c++) begin
         logic [5:0] rd, wr, ld;
         logic [1:0] inc;
         logic hi;
         logic [7:0] d;
         int sel;
         sel = int'($urandom_range(0, 7));
         if (sel < 6) rd = 6'(1 << sel);
         else if (sel == 6) rd = 6'b0;
         else rd = 6'($urandom);
         wr  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
         ld  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'b0;
         inc = 2'($urandom);
         hi  = 1'($urandom);
         d   = 8'($urandom);
         drive(rd, wr, inc, ld, hi, d);
         #1 chk($sformatf("rnd%0d_idu", c), o_IDU_Result, model_idu(inc));
         @(posedge i_Clk);
         model_edge(rd, wr, inc, ld, hi, d);
         #1;
         for (int i = 0; i < 6; i++) chk($sformatf("rnd%0d_pair%0d", c, i), dut_pair(i), m_reg[i]);
         chk($sformatf("rnd%0d_addr", c), o_Addr, m_latch);
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
